instr_mem_server: RTL and testbench
===================================

// Module: instr_mem_server
// PURPOSE
//  Instruction-memory responder on the fetch side of the SIMD core. It serves
//  word reads to the fetch unit: the fetch unit drives PC_AXI and FETCH_REQ;
//  this block returns INSTR_AXI with an INSTR_DONE pulse.
//  Program loading by the host uses an AXI4-Lite write-only slave port.
// PARAMETERS
//  N    256           depth in 32-bit words
//  AW   $clog2(N)     word-address width (derived; do not override)
// PORTS
//  CLK          in   1     clock, all logic on posedge
//  RSTN         in   1     reset, synchronous, active-low
//  PC_AXI       in   AW    fetch word address
//  FETCH_REQ    in   1     fetch request, sampled with PC_AXI
//  INSTR_AXI    out  32    fetched instruction word
//  INSTR_DONE   out  1     1-cycle pulse: INSTR_AXI valid
//  S_AWADDR     in   32    host byte address
//  S_AWVALID    in   1     AW valid
//  S_AWREADY    out  1     AW ready
//  S_WDATA      in   32    write data
//  S_WSTRB      in   4     byte strobes
//  S_WVALID     in   1     W valid
//  S_WREADY     out  1     W ready
//  S_BRESP      out  2     2'b00 OKAY, 2'b10 SLVERR
//  S_BVALID     out  1     B valid
//  S_BREADY     in   1     B ready
// BEHAVIOUR
//  Reset (RSTN=0 at posedge)
//   - INSTR_AXI=0, INSTR_DONE=0, S_BVALID=0, S_BRESP=0, FSM=W_IDLE.
//   - Memory array is not cleared.
//   - Reset mid-transaction discards captured AW/W; no write occurs unless it
//     already committed in an earlier cycle.
//  Fetch
//   - FETCH_REQ=1 in cycle t: mem[PC_AXI] is registered.
//   - INSTR_AXI is valid and INSTR_DONE=1 in cycle t+1. Latency is fixed at 1.
//   - INSTR_AXI holds its value until the next completed fetch.
//   - Back-to-back requests each cycle give one result per cycle. No stall,
//     no backpressure.
//  Write FSM (states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP)
//   - W_IDLE: AWREADY=WREADY=1.
//     - AW and W both fire: commit, go to W_RESP.
//     - Only AW fires: capture address, go to W_HAVE_A.
//     - Only W fires: capture data and strobes, go to W_HAVE_D.
//   - W_HAVE_A: AWREADY=0, WREADY=1. W fires: commit, go to W_RESP.
//   - W_HAVE_D: AWREADY=1, WREADY=0. AW fires: commit, go to W_RESP.
//   - W_RESP: both readies 0, BVALID=1, BRESP held stable.
//     BVALID & BREADY: go to W_IDLE.
//   - BVALID rises the cycle after the commit cycle.
//  Commit rules
//   - Word index = S_AWADDR[AW+1:2].
//   - Per-byte write where WSTRB[i]=1.
//   - BRESP=SLVERR and no write if S_AWADDR[1:0]!=0 or S_AWADDR>=4*N.
//   - WSTRB=4'b0000 with a legal address: OKAY, memory unchanged.
//  Collision
//   - Fetch and commit to the same word in the same cycle: the fetch returns
//     the OLD word (read-before-write). The new word is visible to fetches
//     from the next cycle.
//  Fetch and host write are independent; neither stalls the other.
// TESTING
//  1. Write 0xDEADBEEF @0x10 (AW,W same cycle), BREADY=1
//     -> BVALID one cycle later, BRESP=00; FETCH_REQ,PC=4 -> next cycle
//        INSTR_AXI=0xDEADBEEF, INSTR_DONE=1.
//  2. W two cycles before AW, then BREADY held low 3 cycles
//     -> write lands; BVALID and BRESP stable until BREADY.
//  3. Write @0x402 and @0x400 (N=256)
//     -> SLVERR both; fetch PC=0 shows prior contents unchanged.
//  4. mem[3]=0x11223344; WSTRB=4'b0101, WDATA=0xAABBCCDD
//     -> fetch PC=3 returns 0x11BB33DD.
//  5. FETCH_REQ PC=5 in the same cycle as commit to word 5
//     -> old value returned; fetch next cycle returns new value.
//  6. FETCH_REQ held 4 cycles, PC=0..3 -> INSTR_DONE high 4 cycles with
//     matching words; RSTN low mid-AW (before W) -> FSM W_IDLE, no write.

Source files
------------

// File: rtl/instr_mem_server.sv
// Instruction memory: 1-cycle fetch port for the SIMD fetch unit and an
// AXI4-Lite write-only slave through which the host loads programs.
module instr_mem_server #(
    parameter  int N  = 256,
    localparam int AW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [AW-1:0] PC_AXI,
    input  logic          FETCH_REQ,
    output logic [31:0]   INSTR_AXI,
    output logic          INSTR_DONE,
    input  logic [31:0]   S_AWADDR,
    input  logic          S_AWVALID,
    output logic          S_AWREADY,
    input  logic [31:0]   S_WDATA,
    input  logic [3:0]    S_WSTRB,
    input  logic          S_WVALID,
    output logic          S_WREADY,
    output logic [1:0]    S_BRESP,
    output logic          S_BVALID,
    input  logic          S_BREADY
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] r_mem [N];
    logic [31:0] r_instr;
    logic        r_done;

    wstate_t     r_state;
    wstate_t     w_state_nxt;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;

    logic          w_aw_fire;
    logic          w_w_fire;
    logic          w_commit;
    logic [31:0]   w_cmt_addr;
    logic [31:0]   w_cmt_data;
    logic [3:0]    w_cmt_strb;
    logic [AW-1:0] w_cmt_idx;
    logic          w_cmt_legal;
    logic          w_mem_we;

    assign w_aw_fire = S_AWVALID & S_AWREADY;
    assign w_w_fire  = S_WVALID & S_WREADY;

    // A commit happens on the cycle the second half of the AW/W pair arrives.
    always_comb begin
        w_commit = 1'b0;
        case (r_state)
            W_IDLE:   w_commit = w_aw_fire & w_w_fire;
            W_HAVE_A: w_commit = w_w_fire;
            W_HAVE_D: w_commit = w_aw_fire;
            default:  w_commit = 1'b0;
        endcase
    end

    assign w_cmt_addr  = (r_state == W_HAVE_A) ? r_awaddr : S_AWADDR;
    assign w_cmt_data  = (r_state == W_HAVE_D) ? r_wdata  : S_WDATA;
    assign w_cmt_strb  = (r_state == W_HAVE_D) ? r_wstrb  : S_WSTRB;
    assign w_cmt_idx   = w_cmt_addr[AW+1:2];
    assign w_cmt_legal = (w_cmt_addr[1:0] == 2'b00) && (w_cmt_addr < 32'(4 * N));
    // Gated by RSTN so a transfer completing on a reset edge never lands.
    assign w_mem_we    = w_commit & w_cmt_legal & RSTN;

    // NOTE: the array has no reset branch; clearing it would turn the RAM into
    // flops. Non-blocking writes also give the read-before-write collision rule.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cmt_strb[i]) begin
                    r_mem[w_cmt_idx][8*i +: 8] <= w_cmt_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_instr <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= FETCH_REQ;
            if (FETCH_REQ) begin
                r_instr <= r_mem[PC_AXI];
            end
        end
    end

    assign INSTR_AXI  = r_instr;
    assign INSTR_DONE = r_done;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == W_IDLE && w_aw_fire && !w_w_fire) begin
                r_awaddr <= S_AWADDR;
            end
            if (r_state == W_IDLE && w_w_fire && !w_aw_fire) begin
                r_wdata <= S_WDATA;
                r_wstrb <= S_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_cmt_legal ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_aw_fire && w_w_fire) w_state_nxt = W_RESP;
                else if (w_aw_fire)        w_state_nxt = W_HAVE_A;
                else if (w_w_fire)         w_state_nxt = W_HAVE_D;
            end
            W_HAVE_A: if (w_w_fire)  w_state_nxt = W_RESP;
            W_HAVE_D: if (w_aw_fire) w_state_nxt = W_RESP;
            W_RESP:   if (S_BREADY)  w_state_nxt = W_IDLE;
            default:  w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        S_AWREADY = 1'b0;
        S_WREADY  = 1'b0;
        S_BVALID  = 1'b0;
        case (r_state)
            W_IDLE: begin
                S_AWREADY = 1'b1;
                S_WREADY  = 1'b1;
            end
            W_HAVE_A: S_WREADY  = 1'b1;
            W_HAVE_D: S_AWREADY = 1'b1;
            W_RESP:   S_BVALID  = 1'b1;
            default: ;
        endcase
    end

    assign S_BRESP = r_bresp;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server: a table of host writes each followed by
// a fetch, plus hand-written sequences for ordering, backpressure and reset.
module tb_instr_mem_server;

    localparam int N  = 256;
    localparam int AW = $clog2(N);

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [AW-1:0] PC_AXI;
    logic          FETCH_REQ;
    logic [31:0]   INSTR_AXI;
    logic          INSTR_DONE;
    logic [31:0]   S_AWADDR;
    logic          S_AWVALID;
    logic          S_AWREADY;
    logic [31:0]   S_WDATA;
    logic [3:0]    S_WSTRB;
    logic          S_WVALID;
    logic          S_WREADY;
    logic [1:0]    S_BRESP;
    logic          S_BVALID;
    logic          S_BREADY;

    instr_mem_server #(.N(N)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .PC_AXI     (PC_AXI),
        .FETCH_REQ  (FETCH_REQ),
        .INSTR_AXI  (INSTR_AXI),
        .INSTR_DONE (INSTR_DONE),
        .S_AWADDR   (S_AWADDR),
        .S_AWVALID  (S_AWVALID),
        .S_AWREADY  (S_AWREADY),
        .S_WDATA    (S_WDATA),
        .S_WSTRB    (S_WSTRB),
        .S_WVALID   (S_WVALID),
        .S_WREADY   (S_WREADY),
        .S_BRESP    (S_BRESP),
        .S_BVALID   (S_BVALID),
        .S_BREADY   (S_BREADY)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [1:0]    bresp;
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        FETCH_REQ = 1'b0;
        PC_AXI    = '0;
        S_AWADDR  = '0;
        S_AWVALID = 1'b0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [AW-1:0] pc, input logic [31:0] exp);
        PC_AXI    = pc;
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        check({name, " done"}, 32'(INSTR_DONE), 32'd1);
        check({name, " instr"}, INSTR_AXI, exp);
        tick();
        check({name, " done_drop"}, 32'(INSTR_DONE), 32'd0);
        check({name, " hold"}, INSTR_AXI, exp);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h0123_4567, 4'hF, 2'b00, 8'd0,   32'h0123_4567};
        vecs[1]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'd4,   32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0402, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'd0,   32'h0123_4567};
        vecs[3]  = '{32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'd0,   32'h0123_4567};
        vecs[4]  = '{32'h0000_000C, 32'h1122_3344, 4'hF, 2'b00, 8'd3,   32'h1122_3344};
        vecs[5]  = '{32'h0000_000C, 32'hAABB_CCDD, 4'h5, 2'b00, 8'd3,   32'h11BB_33DD};
        vecs[6]  = '{32'h0000_0008, 32'h2222_2222, 4'hF, 2'b00, 8'd2,   32'h2222_2222};
        vecs[7]  = '{32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 2'b00, 8'd2,   32'h2222_2222};
        vecs[8]  = '{32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 2'b00, 8'd255, 32'hCAFE_F00D};
        vecs[9]  = '{32'h0000_03FE, 32'h0000_0000, 4'hF, 2'b10, 8'd255, 32'hCAFE_F00D};
        vecs[10] = '{32'h0000_0014, 32'h5555_5555, 4'hF, 2'b00, 8'd5,   32'h5555_5555};
        vecs[11] = '{32'h0000_0004, 32'h0BAD_F00D, 4'hF, 2'b00, 8'd1,   32'h0BAD_F00D};
        vecs[12] = '{32'h8000_0000, 32'h0000_0000, 4'hF, 2'b10, 8'd0,   32'h0123_4567};

        idle_inputs();
        RSTN = 1'b0;
        tick();
        tick();
        check("rst instr",   INSTR_AXI, 32'h0);
        check("rst done",    32'(INSTR_DONE), 32'd0);
        check("rst bvalid",  32'(S_BVALID), 32'd0);
        check("rst bresp",   32'(S_BRESP), 32'd0);
        check("rst awready", 32'(S_AWREADY), 32'd1);
        check("rst wready",  32'(S_WREADY), 32'd1);
        RSTN = 1'b1;
        tick();

        // AW and W in the same cycle, response accepted at once, then fetch.
        for (int i = 0; i < 13; i++) begin
            S_AWADDR  = vecs[i].addr;
            S_WDATA   = vecs[i].data;
            S_WSTRB   = vecs[i].strb;
            S_AWVALID = 1'b1;
            S_WVALID  = 1'b1;
            S_BREADY  = 1'b1;
            tick();
            S_AWVALID = 1'b0;
            S_WVALID  = 1'b0;
            check($sformatf("vec%0d bvalid", i), 32'(S_BVALID), 32'd1);
            check($sformatf("vec%0d bresp", i),  32'(S_BRESP), 32'(vecs[i].bresp));
            tick();
            check($sformatf("vec%0d bvalid_drop", i), 32'(S_BVALID), 32'd0);
            S_BREADY = 1'b0;
            fetch($sformatf("vec%0d fetch", i), vecs[i].pc, vecs[i].instr);
        end

        // W two cycles ahead of AW, then B held off for 3 cycles.
        S_WDATA  = 32'h1357_9BDF;
        S_WSTRB  = 4'hF;
        S_WVALID = 1'b1;
        tick();
        S_WVALID = 1'b0;
        check("wfirst wready",  32'(S_WREADY), 32'd0);
        check("wfirst awready", 32'(S_AWREADY), 32'd1);
        tick();
        check("wfirst wait bvalid", 32'(S_BVALID), 32'd0);
        S_AWADDR  = 32'h0000_0018;
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp%0d bvalid", i), 32'(S_BVALID), 32'd1);
            check($sformatf("bp%0d bresp", i),  32'(S_BRESP), 32'd0);
            check($sformatf("bp%0d awready", i), 32'(S_AWREADY), 32'd0);
            if (i < 3) tick();
        end
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        check("bp release bvalid", 32'(S_BVALID), 32'd0);
        fetch("wfirst fetch", 8'd6, 32'h1357_9BDF);

        // AW one cycle ahead of W, misaligned: SLVERR, nothing written.
        S_AWADDR  = 32'h0000_0019;
        S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        check("afirst awready", 32'(S_AWREADY), 32'd0);
        check("afirst wready",  32'(S_WREADY), 32'd1);
        S_WDATA  = 32'h0000_0000;
        S_WSTRB  = 4'hF;
        S_WVALID = 1'b1;
        S_BREADY = 1'b1;
        tick();
        S_WVALID = 1'b0;
        check("afirst bresp", 32'(S_BRESP), 32'h2);
        tick();
        S_BREADY = 1'b0;
        fetch("afirst fetch", 8'd6, 32'h1357_9BDF);

        // Fetch and commit to word 5 in the same cycle: old word first.
        S_AWADDR  = 32'h0000_0014;
        S_WDATA   = 32'h6666_6666;
        S_WSTRB   = 4'hF;
        S_AWVALID = 1'b1;
        S_WVALID  = 1'b1;
        S_BREADY  = 1'b1;
        PC_AXI    = 8'd5;
        FETCH_REQ = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        check("coll old", INSTR_AXI, 32'h5555_5555);
        tick();
        check("coll new", INSTR_AXI, 32'h6666_6666);
        check("coll done", 32'(INSTR_DONE), 32'd1);
        FETCH_REQ = 1'b0;
        S_BREADY  = 1'b0;
        tick();

        // Back-to-back fetches, one result per cycle.
        begin
            logic [31:0] exp_words [4];
            exp_words = '{32'h0123_4567, 32'h0BAD_F00D, 32'h2222_2222, 32'h11BB_33DD};
            FETCH_REQ = 1'b1;
            for (int i = 0; i < 4; i++) begin
                PC_AXI = AW'(i);
                tick();
                check($sformatf("b2b%0d done", i),  32'(INSTR_DONE), 32'd1);
                check($sformatf("b2b%0d instr", i), INSTR_AXI, exp_words[i]);
            end
            FETCH_REQ = 1'b0;
            tick();
            check("b2b end done", 32'(INSTR_DONE), 32'd0);
            check("b2b end hold", INSTR_AXI, 32'h11BB_33DD);
        end

        // Reset while holding a captured address; AW+W also on the reset edge.
        S_AWADDR  = 32'h0000_0010;
        S_AWVALID = 1'b1;
        tick();
        check("mid awready", 32'(S_AWREADY), 32'd0);
        S_WDATA  = 32'h0000_0000;
        S_WSTRB  = 4'hF;
        S_WVALID = 1'b1;
        RSTN     = 1'b0;
        tick();
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        RSTN      = 1'b1;
        check("mid rst awready", 32'(S_AWREADY), 32'd1);
        check("mid rst wready",  32'(S_WREADY), 32'd1);
        check("mid rst bvalid",  32'(S_BVALID), 32'd0);
        check("mid rst instr",   INSTR_AXI, 32'h0);
        tick();
        check("post rst bvalid", 32'(S_BVALID), 32'd0);
        fetch("post rst fetch", 8'd4, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
